// File: rtl/uart_rx_fsm_if.sv
// Signal bundle between the UART receive sequencer and its datapath
// neighbours: the serial line, the edge/bit counter, the sampler and
// deserializer, and the start/parity/stop checkers.
interface uart_rx_fsm_if #(
  parameter int CNT_WIDTH = 6
);
  // Line and frame configuration
  logic                 rx_in_fsm;
  logic                 par_en_fsm;
  logic [CNT_WIDTH-1:0] prescale_fsm;
  // Counter position
  logic [CNT_WIDTH-1:0] edge_cnt_fsm;
  logic [CNT_WIDTH-1:0] bit_cnt_fsm;
  // Checker results
  logic                 strt_glitch_fsm;
  logic                 par_err_fsm;
  logic                 stp_err_fsm;
  // Sequencer strobes and frame results
  logic                 edge_bit_en_fsm;
  logic                 dat_samp_en_fsm;
  logic                 deser_en_fsm;
  logic                 strt_chk_en_fsm;
  logic                 par_chk_en_fsm;
  logic                 stp_chk_en_fsm;
  logic                 data_valid_fsm;
  logic                 par_err_out_fsm;
  logic                 stp_err_out_fsm;

  // The sequencer itself
  modport slave (
    input  rx_in_fsm, par_en_fsm, prescale_fsm, edge_cnt_fsm, bit_cnt_fsm,
    input  strt_glitch_fsm, par_err_fsm, stp_err_fsm,
    output edge_bit_en_fsm, dat_samp_en_fsm, deser_en_fsm, strt_chk_en_fsm,
    output par_chk_en_fsm, stp_chk_en_fsm, data_valid_fsm, par_err_out_fsm,
    output stp_err_out_fsm
  );

  // The surrounding receiver datapath
  modport master (
    output rx_in_fsm, par_en_fsm, prescale_fsm, edge_cnt_fsm, bit_cnt_fsm,
    output strt_glitch_fsm, par_err_fsm, stp_err_fsm,
    input  edge_bit_en_fsm, dat_samp_en_fsm, deser_en_fsm, strt_chk_en_fsm,
    input  par_chk_en_fsm, stp_chk_en_fsm, data_valid_fsm, par_err_out_fsm,
    input  stp_err_out_fsm
  );
endinterface

// File: rtl/uart_rx_fsm.sv
// UART receive frame sequencer. Detects the start bit, enables the external
// edge/bit counter, decodes the counter position into sampler, deserializer
// and checker strobes, and reports each completed frame with a single-cycle
// data_valid or error pulse.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 6
) (
  input  logic          CLK_FSM,
  input  logic          RST_FSM,
  uart_rx_fsm_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DATA_LAST = CNT_WIDTH'(DATA_WIDTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO   = CNT_WIDTH'(2);

  state_t               state_r;
  logic [CNT_WIDTH-1:0] prescale_r;    // P, frozen for the whole frame
  logic                 par_sticky_r;  // parity failure carried to DONE

  logic [CNT_WIDTH-1:0] half_s;
  logic                 last_edge_s;
  logic                 samp_win_s;
  logic                 chk_pt_s;

  logic edge_bit_en_s;
  logic dat_samp_en_s;
  logic deser_en_s;
  logic strt_chk_en_s;
  logic par_chk_en_s;
  logic stp_chk_en_s;
  logic data_valid_s;
  logic par_err_out_s;
  logic stp_err_out_s;

  // Position within the current bit, measured against the latched P
  always_comb begin
    half_s      = {1'b0, prescale_r[CNT_WIDTH-1:1]};
    last_edge_s = (bus.edge_cnt_fsm == (prescale_r - CNT_ONE));
    samp_win_s  = (bus.edge_cnt_fsm == (half_s - CNT_TWO)) ||
                  (bus.edge_cnt_fsm == (half_s - CNT_ONE)) ||
                  (bus.edge_cnt_fsm == half_s);
    chk_pt_s    = (bus.edge_cnt_fsm == (half_s + CNT_ONE));
  end

  // Frame state machine, latched prescale and sticky parity flag
  always_ff @(posedge CLK_FSM) begin
    if (!RST_FSM) begin
      state_r      <= IDLE;
      prescale_r   <= '0;
      par_sticky_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!bus.rx_in_fsm) begin
            state_r      <= START;
            prescale_r   <= bus.prescale_fsm;
            par_sticky_r <= 1'b0;
          end
        end
        START: begin
          // A glitch can only abort once the whole start bit has elapsed
          if (last_edge_s) begin
            state_r <= bus.strt_glitch_fsm ? IDLE : DATA;
          end
        end
        DATA: begin
          // >= rather than == so a counter that overshoots cannot strand us
          if (last_edge_s && (bus.bit_cnt_fsm >= DATA_LAST)) begin
            state_r <= bus.par_en_fsm ? PARITY : STOP;
          end
        end
        PARITY: begin
          // Parity failure does not abort; it is reported with the stop result
          if (last_edge_s) begin
            state_r      <= STOP;
            par_sticky_r <= par_sticky_r | bus.par_err_fsm;
          end
        end
        STOP: begin
          if (last_edge_s) begin
            state_r <= DONE;
          end
        end
        DONE: begin
          // Line already low: the next start bit follows without an idle gap
          if (!bus.rx_in_fsm) begin
            state_r      <= START;
            prescale_r   <= bus.prescale_fsm;
            par_sticky_r <= 1'b0;
          end else begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r      <= IDLE;
          par_sticky_r <= 1'b0;
        end
      endcase
    end
  end

  // Strobe and result decode; combinational so each strobe coincides with
  // the counter value it refers to
  always_comb begin
    edge_bit_en_s = 1'b0;
    dat_samp_en_s = 1'b0;
    deser_en_s    = 1'b0;
    strt_chk_en_s = 1'b0;
    par_chk_en_s  = 1'b0;
    stp_chk_en_s  = 1'b0;
    data_valid_s  = 1'b0;
    par_err_out_s = 1'b0;
    stp_err_out_s = 1'b0;
    case (state_r)
      IDLE: begin
        edge_bit_en_s = 1'b0;
      end
      START: begin
        edge_bit_en_s = 1'b1;
        dat_samp_en_s = samp_win_s;
        strt_chk_en_s = chk_pt_s;
      end
      DATA: begin
        edge_bit_en_s = 1'b1;
        dat_samp_en_s = samp_win_s;
        deser_en_s    = chk_pt_s;
      end
      PARITY: begin
        edge_bit_en_s = 1'b1;
        dat_samp_en_s = samp_win_s;
        par_chk_en_s  = chk_pt_s;
      end
      STOP: begin
        edge_bit_en_s = 1'b1;
        dat_samp_en_s = samp_win_s;
        stp_chk_en_s  = chk_pt_s;
      end
      DONE: begin
        data_valid_s  = ~par_sticky_r & ~bus.stp_err_fsm;
        par_err_out_s = par_sticky_r;
        stp_err_out_s = bus.stp_err_fsm;
      end
      default: begin
        edge_bit_en_s = 1'b0;
      end
    endcase
  end

  assign bus.edge_bit_en_fsm = edge_bit_en_s;
  assign bus.dat_samp_en_fsm = dat_samp_en_s;
  assign bus.deser_en_fsm    = deser_en_s;
  assign bus.strt_chk_en_fsm = strt_chk_en_s;
  assign bus.par_chk_en_fsm  = par_chk_en_s;
  assign bus.stp_chk_en_fsm  = stp_chk_en_s;
  assign bus.data_valid_fsm  = data_valid_s;
  assign bus.par_err_out_fsm = par_err_out_s;
  assign bus.stp_err_out_fsm = stp_err_out_s;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: behavioural edge/bit counter and
// checkers around the DUT, directed frames pushed into a scoreboard, and a
// monitor that compares every frame-result pulse against it.
module tb_uart_rx_fsm;
  localparam int DW = 8;
  localparam int CW = 6;

  typedef struct {
    logic [7:0] data;
    logic       valid;
    logic       perr;
    logic       serr;
    int         done_cyc;
    int         nbits;
    logic       pe;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic [CW-1:0] cnt_p;
  logic [7:0]    data_sh;
  exp_t exp_q[$];
  exp_t mon_e;
  int   last_done = 0;
  int   n_deser = 0, n_samp = 0, n_strt = 0, n_par = 0, n_stp = 0;

  always #5 clk = ~clk;

  uart_rx_fsm_if #(.CNT_WIDTH(CW)) bus ();

  uart_rx_fsm #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .CLK_FSM (clk),
    .RST_FSM (rst_n),
    .bus     (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Edge/bit counter model
  always @(posedge clk) begin
    if (!rst_n || !bus.edge_bit_en_fsm) begin
      bus.edge_cnt_fsm <= 6'd0;
      bus.bit_cnt_fsm  <= 6'd0;
    end else if (bus.edge_cnt_fsm == cnt_p - 6'd1) begin
      bus.edge_cnt_fsm <= 6'd0;
      bus.bit_cnt_fsm  <= bus.bit_cnt_fsm + 6'd1;
    end else begin
      bus.edge_cnt_fsm <= bus.edge_cnt_fsm + 6'd1;
    end
  end

  // Checker and deserializer models, registered on their strobes
  always @(posedge clk) begin
    if (!rst_n) begin
      bus.strt_glitch_fsm <= 1'b0;
      bus.par_err_fsm     <= 1'b0;
      bus.stp_err_fsm     <= 1'b0;
      data_sh             <= 8'h00;
    end else begin
      if (bus.strt_chk_en_fsm) bus.strt_glitch_fsm <= bus.rx_in_fsm;
      if (bus.par_chk_en_fsm)  bus.par_err_fsm     <= bus.rx_in_fsm ^ (^data_sh);
      if (bus.stp_chk_en_fsm)  bus.stp_err_fsm     <= ~bus.rx_in_fsm;
      if (bus.deser_en_fsm)    data_sh             <= {bus.rx_in_fsm, data_sh[7:1]};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic logic [8:0] all_outs();
    return {bus.edge_bit_en_fsm, bus.dat_samp_en_fsm, bus.deser_en_fsm,
            bus.strt_chk_en_fsm, bus.par_chk_en_fsm, bus.stp_chk_en_fsm,
            bus.data_valid_fsm, bus.par_err_out_fsm, bus.stp_err_out_fsm};
  endfunction

  // Monitor: tally strobes per frame, compare each result pulse with the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.deser_en_fsm)    n_deser++;
      if (bus.dat_samp_en_fsm) n_samp++;
      if (bus.strt_chk_en_fsm) n_strt++;
      if (bus.par_chk_en_fsm)  n_par++;
      if (bus.stp_chk_en_fsm)  n_stp++;
      if (bus.deser_en_fsm || bus.strt_chk_en_fsm || bus.par_chk_en_fsm || bus.stp_chk_en_fsm) begin
        chk("chk_strobe_edge", 32'(bus.edge_cnt_fsm), 32'(cnt_p / 6'd2 + 6'd1));
        chk("chk_strobe_onehot",
            32'($countones({bus.deser_en_fsm, bus.strt_chk_en_fsm, bus.par_chk_en_fsm, bus.stp_chk_en_fsm})),
            32'd1);
      end
      if (bus.data_valid_fsm || bus.par_err_out_fsm || bus.stp_err_out_fsm) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: got valid=%b perr=%b serr=%b expected no pulse (cycle %0d)",
                   bus.data_valid_fsm, bus.par_err_out_fsm, bus.stp_err_out_fsm, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("data_valid",  32'(bus.data_valid_fsm),  32'(mon_e.valid));
          chk("par_err_out", 32'(bus.par_err_out_fsm), 32'(mon_e.perr));
          chk("stp_err_out", 32'(bus.stp_err_out_fsm), 32'(mon_e.serr));
          chk("done_cycle",  32'(cyc),                 32'(mon_e.done_cyc));
          chk("frame_data",  32'(data_sh),             32'(mon_e.data));
          chk("deser_count", 32'(n_deser),             32'(DW));
          chk("samp_count",  32'(n_samp),              32'(3 * mon_e.nbits));
          chk("strt_count",  32'(n_strt),              32'd1);
          chk("par_count",   32'(n_par),               32'(mon_e.pe));
          chk("stp_count",   32'(n_stp),               32'd1);
        end
      end
    end
    if (!bus.edge_bit_en_fsm) begin
      n_deser = 0; n_samp = 0; n_strt = 0; n_par = 0; n_stp = 0;
    end
  end

  task automatic idle(input int n);
    bus.rx_in_fsm = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive one frame starting just after an edge; b2b means the DUT re-enters
  // START from DONE, p_mid (if nonzero) replaces prescale after the start bit
  task automatic send_frame(input logic [7:0] d, input int p, input logic pe,
                            input logic pbad, input logic stop_b, input logic b2b,
                            input int p_mid);
    exp_t e;
    logic [10:0] fb;
    int k;
    int nb;
    nb = DW + 2 + int'(pe);
    fb = 11'd0;
    fb[8:1] = d;
    if (pe) begin
      fb[9]  = (^d) ^ pbad;
      fb[10] = stop_b;
    end else begin
      fb[9] = stop_b;
    end
    bus.prescale_fsm = CW'(p);
    bus.par_en_fsm   = pe;
    cnt_p            = CW'(p);
    k = b2b ? last_done + 1 : cyc + 1;
    e.data = d; e.valid = ~pbad & stop_b; e.perr = pbad; e.serr = ~stop_b;
    e.done_cyc = k + nb * p; e.nbits = nb; e.pe = pe;
    exp_q.push_back(e);
    last_done = e.done_cyc;
    for (int i = 0; i < nb; i++) begin
      bus.rx_in_fsm = fb[i];
      if (i == 1 && p_mid != 0) bus.prescale_fsm = CW'(p_mid);
      repeat (p) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int k;
    rst_n = 1'b0;
    bus.rx_in_fsm = 1'b1;
    bus.par_en_fsm = 1'b0;
    bus.prescale_fsm = 6'd8;
    cnt_p = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    idle(5);
    chk("idle_outputs", 32'(all_outs()), 32'd0);

    // 1: P=8, no parity, 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(20);
    // 2: P=16, even parity correct, 0x3C
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(20);
    // 3: P=8, parity bit inverted
    send_frame(8'h96, 8, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    idle(20);
    // 4: stop bit low, then immediate back-to-back frame
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    idle(20);

    // 5: two-cycle start glitch, then a clean 0x00 frame
    cnt_p = 6'd8;
    bus.prescale_fsm = 6'd8;
    bus.par_en_fsm = 1'b0;
    k = cyc + 1;
    bus.rx_in_fsm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    bus.rx_in_fsm = 1'b1;
    wait_cyc(k + 7);
    chk("glitch_still_start", 32'(bus.edge_bit_en_fsm), 32'd1);
    wait_cyc(k + 8);
    chk("glitch_to_idle", 32'(all_outs()), 32'd0);
    idle(10);
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    idle(20);

    // 6a: P=32, reset during data bit 4
    cnt_p = 6'd32;
    bus.prescale_fsm = 6'd32;
    k = cyc + 1;
    bus.rx_in_fsm = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    bus.rx_in_fsm = 1'b1;
    wait_cyc(k + 4 * 32 + 10);
    chk("pre_reset_active", 32'(bus.edge_bit_en_fsm), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_frame_reset_outputs", 32'(all_outs()), 32'd0);
    rst_n = 1'b1;
    idle(40);
    chk("post_reset_idle", 32'(all_outs()), 32'd0);

    // 6b: prescale changed 32 -> 8 after the start bit
    send_frame(8'hC3, 32, 1'b0, 1'b0, 1'b1, 1'b0, 8);
    idle(40);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Frame-sequencing controller for the UART receiver.
- Detects the start bit and drives the enable of the edge/bit counter. Decodes the counter's edge_cnt/bit_cnt into sampler, deserializer and checker strobes.
- Walks START, DATA, optional PARITY and STOP.
- Issues a one-cycle data_valid or error pulse per frame.

Parameters:
- DATA_WIDTH, 8, data bits per frame (1..16)
- CNT_WIDTH, 6, width of prescale / edge / bit count buses

Ports:
- CLK_FSM  input  1  receiver clock (oversampling clock)
- RST_FSM  input  1  reset; synchronous, active-low
- rx_in_fsm  input  1  serial line, idle high
- par_en_fsm  input  1  1 = frame carries a parity bit
- prescale_fsm  input  CNT_WIDTH  oversampling ratio; legal values even, 8..32
- edge_cnt_fsm  input  CNT_WIDTH  edge count from counter, 0..P-1 within a bit
- bit_cnt_fsm  input  CNT_WIDTH  bit index from counter (start = 0)
- strt_glitch_fsm  input  1  start checker result, registered on strt_chk_en
- par_err_fsm  input  1  parity checker result, registered on par_chk_en
- stp_err_fsm  input  1  stop checker result, registered on stp_chk_en
- edge_bit_en_fsm  output  1  enable to edge/bit counter
- dat_samp_en_fsm  output  1  sampler enable
- deser_en_fsm  output  1  deserializer shift strobe
- strt_chk_en_fsm  output  1  start-check strobe
- par_chk_en_fsm  output  1  parity-check strobe
- stp_chk_en_fsm  output  1  stop-check strobe
- data_valid_fsm  output  1  frame accepted, one-cycle pulse
- par_err_out_fsm  output  1  parity failure, one-cycle pulse
- stp_err_out_fsm  output  1  framing failure, one-cycle pulse

Behaviour:
- Clock and reset: all state on posedge CLK_FSM. When RST_FSM=0 at an edge, the next state is IDLE, latched prescale is cleared, and all outputs are 0.
- Reset mid-frame aborts the frame. No valid or error pulse is issued.
- P is prescale_fsm latched on the IDLE->START (or DONE->START) transition. Changes to prescale_fsm mid-frame are ignored until the next frame.
- Let H = P/2. All comparisons use latched P, at CNT_WIDTH bits, unsigned.
- Outputs are Moore/decoded: combinational from state, edge_cnt_fsm and bit_cnt_fsm. No registered output latency.

States:
- IDLE:
  - All outputs 0.
  - rx_in_fsm=0 at an edge -> START.
- START:
  - edge_bit_en=1.
  - At edge_cnt = P-1: strt_glitch=1 -> IDLE (no pulses); else -> DATA.
- DATA:
  - edge_bit_en=1.
  - At edge_cnt = P-1 with bit_cnt = DATA_WIDTH: par_en_fsm=1 -> PARITY, else -> STOP.
  - par_en_fsm is sampled at that transition.
- PARITY:
  - edge_bit_en=1.
  - At edge_cnt = P-1 -> STOP. A parity error does not abort; it is carried to DONE.
  - par_err is held in an internal sticky flag, cleared on entry to START.
- STOP:
  - edge_bit_en=1.
  - At edge_cnt = P-1 -> DONE.
- DONE:
  - Lasts exactly one cycle; edge_bit_en=0, so the counter clears.
  - data_valid=1 iff the sticky parity flag=0 and stp_err=0.
  - par_err_out=sticky parity flag; stp_err_out=stp_err. Both errors may pulse together.
  - Exit: rx_in_fsm=0 -> START (back-to-back frame, P re-latched); else -> IDLE.

Strobes (asserted in every non-IDLE, non-DONE state):
- dat_samp_en=1 while edge_cnt in {H-2, H-1, H}. Three-sample majority is done in the sampler.
- Check strobe = 1 for one cycle at edge_cnt = H+1, routed by state:
  - START -> strt_chk_en
  - DATA -> deser_en
  - PARITY -> par_chk_en
  - STOP -> stp_chk_en
- At most one check strobe is high in any cycle.

Timing:
- Let k be the edge at which IDLE sees rx_in_fsm=0.
- DONE occupies the cycle beginning at edge k + (DATA_WIDTH + 2 + par_en)·P.

Boundary cases:
- A glitch aborts at the end of the start bit only, never earlier.
- rx_in_fsm low continuously is treated as a frame with a stop error, not a hang.
- Illegal P (odd, or <8) is unsupported; behaviour is undefined but must not deadlock. Every state exits within P cycles of edge_cnt reaching P-1.

Test Plan:
1. P=8, par_en=0, frame 0xA5 LSB first, valid stop -> deser_en pulses 8 times at edge_cnt=5; data_valid=1 for exactly one cycle at k+80; no error pulses.
2. P=16, par_en=1, even-parity frame 0x3C with correct parity -> DONE at k+176; data_valid=1; par_chk_en pulses once at edge_cnt=9.
3. P=8, par_en=1, parity bit inverted (checker returns par_err=1) -> par_err_out=1 and data_valid=0 at k+88.
4. P=8, stop bit driven 0 -> stp_err_out=1, data_valid=0. Line held low after DONE -> immediate START; second frame decodes correctly.
5. P=8, rx_in low for 2 cycles then high (checker reports strt_glitch=1) -> IDLE at k+8; edge_bit_en=0; no pulses. The next clean frame 0x00 is received.
6. P=32, RST_FSM=0 during data bit 4 -> next cycle IDLE, all outputs 0, no pulses. prescale_fsm changed 32->8 mid-frame in a separate run -> frame still timed at P=32.
